mmio_peripherals: RTL and testbench

//  Memory-mapped board I/O for the ARM pipeline: LEDs, switches, a push-button and NDIG 7-segment digits.

---
 rtl/mmio_peripherals.sv | 142 ++++++++++++++
 tb/tb_mmio_peripherals.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mmio_peripherals.sv
// Memory-mapped LEDs, switches, debounced push-button and 7-segment digits on the data bus.
// Optional button interrupt (STATUS bit2 enable, irq output) is built when PERIPH_BTN_IRQ_EN is defined.
module mmio_peripherals #(
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0400,
    parameter int          NLED            = 10,
    parameter int          NSW             = 10,
    parameter int          NDIG            = 6,
    parameter int          DEBOUNCE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    input  logic              button,
    input  logic [NSW-1:0]    switches,
    output logic [NLED-1:0]   leds,
    output logic [7*NDIG-1:0] hex,
    output logic              irq
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [NLED-1:0]   ledQ;
    logic [4*NDIG-1:0] hexQ;
    logic [NSW-1:0]    swSync1Q, swSync2Q;
    logic              btnSync1Q, btnSync2Q;
    logic [CW-1:0]     cntQ, cntD, cntInc;
    logic              levelQ, levelD, eventQ, eventD;
    logic              toggle, rise;
    logic              sel, wrLed, wrHex, wrStatus;
    logic [3:0]        off;

    assign sel      = (addr[31:4] == BASE_ADDR[31:4]);
    assign off      = addr[3:0];
    assign wrLed    = we && sel && (off == 4'h0);
    assign wrHex    = we && sel && (off == 4'h8);
    assign wrStatus = we && sel && (off == 4'hC);

    // The debounced level toggles on the DEBOUNCE_CYCLES-th consecutive disagreeing cycle.
    always_comb begin
        cntInc = cntQ + CW'(1);
        toggle = (btnSync2Q != levelQ) && (cntInc == CW'(DEBOUNCE_CYCLES));
        rise   = toggle && !levelQ;
        levelD = toggle ? ~levelQ : levelQ;
        cntD   = ((btnSync2Q == levelQ) || toggle) ? '0 : cntInc;
        eventD = eventQ;
        if (wrStatus && wdata[1]) eventD = 1'b0;
        if (rise)                 eventD = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ledQ      <= '0;
            hexQ      <= '0;
            swSync1Q  <= '0;
            swSync2Q  <= '0;
            btnSync1Q <= 1'b0;
            btnSync2Q <= 1'b0;
            cntQ      <= '0;
            levelQ    <= 1'b0;
            eventQ    <= 1'b0;
        end else begin
            if (wrLed) ledQ <= wdata[NLED-1:0];
            if (wrHex) hexQ <= wdata[4*NDIG-1:0];
            swSync1Q  <= switches;
            swSync2Q  <= swSync1Q;
            btnSync1Q <= button;
            btnSync2Q <= btnSync1Q;
            cntQ      <= cntD;
            levelQ    <= levelD;
            eventQ    <= eventD;
        end
    end

`ifdef PERIPH_BTN_IRQ_EN
    logic enableQ, irqQ;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enableQ <= 1'b0;
            irqQ    <= 1'b0;
        end else begin
            if (wrStatus) enableQ <= wdata[2];
            irqQ <= eventQ && enableQ;
        end
    end

    assign irq = irqQ;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (off)
                4'h0: rdata[NLED-1:0]   = ledQ;
                4'h4: rdata[NSW-1:0]    = swSync2Q;
                4'h8: rdata[4*NDIG-1:0] = hexQ;
                4'hC: begin
                    rdata[0] = levelQ;
                    rdata[1] = eventQ;
`ifdef PERIPH_BTN_IRQ_EN
                    rdata[2] = enableQ;
`endif
                end
                default: rdata = '0;
            endcase
        end
    end

    // Segment order {g,f,e,d,c,b,a}, active-low.
    function automatic logic [6:0] segDecode(input logic [3:0] nib);
        case (nib)
            4'h0: segDecode = 7'b1000000;
            4'h1: segDecode = 7'b1111001;
            4'h2: segDecode = 7'b0100100;
            4'h3: segDecode = 7'b0110000;
            4'h4: segDecode = 7'b0011001;
            4'h5: segDecode = 7'b0010010;
            4'h6: segDecode = 7'b0000010;
            4'h7: segDecode = 7'b1111000;
            4'h8: segDecode = 7'b0000000;
            4'h9: segDecode = 7'b0010000;
            4'hA: segDecode = 7'b0001000;
            4'hB: segDecode = 7'b0000011;
            4'hC: segDecode = 7'b1000110;
            4'hD: segDecode = 7'b0100001;
            4'hE: segDecode = 7'b0000110;
            default: segDecode = 7'b0001110;
        endcase
    endfunction

    for (genvar i = 0; i < NDIG; i++) begin : gDigit
        assign hex[7*i +: 7] = segDecode(hexQ[4*i +: 4]);
    end

    assign leds = ledQ;

endmodule

// File: tb/tb_mmio_peripherals.sv
// Directed self-checking bench for mmio_peripherals with default parameters.
// Expected values are hand-computed from the register map and segment table.
module tb_mmio_peripherals;

`ifdef PERIPH_BTN_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    localparam logic [41:0] HEX_ZERO = {6{7'b1000000}};

    logic        clk, reset, we, button, irq;
    logic [31:0] addr, wdata, rdata, rd;
    logic [9:0]  switches, leds;
    logic [41:0] hex;
    int          checkCount, errorCount;

    mmio_peripherals dut (
        .clk(clk), .reset(reset), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata),
        .button(button), .switches(switches), .leds(leds), .hex(hex), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; wdata = d;
        tick(1);
        we = 1'b0;
    endtask

    task automatic readBus(input logic [31:0] a, output logic [31:0] d);
        we = 1'b0; addr = a;
        #1;
        d = rdata;
    endtask

    initial begin
        checkCount = 0; errorCount = 0;
        clk = 0; reset = 1; we = 0; addr = 0; wdata = 0; button = 0; switches = 0;

        #12;
        checkOutput("reset_leds", leds, 0);
        checkOutput("reset_hex", hex, HEX_ZERO);
        checkOutput("reset_irq", irq, 0);
        readBus(32'h40C, rd); checkOutput("reset_status", rd, 0);
        @(posedge clk); #1; reset = 0;
        tick(1);
        checkOutput("post_reset_leds", leds, 0);
        checkOutput("post_reset_hex", hex, HEX_ZERO);

        applyStimulus(32'h400, 32'h3FF);
        checkOutput("leds_3ff", leds, 10'h3FF);
        applyStimulus(32'h408, 32'h0012_3456);
        checkOutput("hex_123456", hex,
            {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010});
        readBus(32'h408, rd); checkOutput("read_hex", rd, 32'h0012_3456);
        applyStimulus(32'h408, 32'hFFFE_DCBA);
        checkOutput("hex_fedcba", hex,
            {7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110, 7'b0000011, 7'b0001000});
        readBus(32'h408, rd); checkOutput("read_hex_trunc", rd, 32'h00FE_DCBA);
        applyStimulus(32'h408, 32'h0007_8900);
        checkOutput("hex_078900", hex,
            {7'b1000000, 7'b1111000, 7'b0000000, 7'b0010000, 7'b1000000, 7'b1000000});

        applyStimulus(32'h400, 32'hFFFF_FC55);
        readBus(32'h400, rd); checkOutput("led_trunc", rd, 32'h55);
        applyStimulus(32'h410, 32'h3FF);
        checkOutput("outside_write_ignored", leds, 10'h055);
        applyStimulus(32'h401, 32'h3FF);
        checkOutput("unmapped_write_ignored", leds, 10'h055);
        readBus(32'h401, rd); checkOutput("unmapped_read", rd, 0);

        switches = 10'b1110111101;
        tick(1);
        readBus(32'h404, rd); checkOutput("sw_latency", rd, 0);
        tick(1);
        readBus(32'h404, rd); checkOutput("sw_synced", rd, 32'h3BD);
        readBus(32'h410, rd); checkOutput("outside_read", rd, 0);

        button = 1; tick(10); button = 0; tick(30);
        readBus(32'h40C, rd); checkOutput("glitch_ignored", rd, 0);

        button = 1; tick(17);
        readBus(32'h40C, rd); checkOutput("press_before_edge", rd, 0);
        tick(1);
        readBus(32'h40C, rd); checkOutput("press_level_event", rd, 3);
        tick(20);
        applyStimulus(32'h40C, 32'h0);
        readBus(32'h40C, rd); checkOutput("w0_no_effect", rd, 3);
        applyStimulus(32'h40C, 32'h2);
        readBus(32'h40C, rd); checkOutput("w1c_clear", rd, 1);
        button = 0; tick(30);
        readBus(32'h40C, rd); checkOutput("release_no_event", rd, 0);

        button = 1; tick(17);
        applyStimulus(32'h40C, 32'h2);
        readBus(32'h40C, rd); checkOutput("set_wins_over_clear", rd, 3);
        button = 0; tick(30);
        readBus(32'h40C, rd); checkOutput("event_sticky", rd, 2);
        applyStimulus(32'h40C, 32'h2);
        readBus(32'h40C, rd); checkOutput("w1c_no_press", rd, 0);

        applyStimulus(32'h40C, 32'h4);
        readBus(32'h40C, rd); checkOutput("enable_bit", rd, IRQ_EN ? 32'h4 : 32'h0);
        button = 1; tick(18);
        readBus(32'h40C, rd); checkOutput("irq_press_status", rd, IRQ_EN ? 32'h7 : 32'h3);
        checkOutput("irq_same_cycle", irq, 0);
        tick(1);
        checkOutput("irq_asserted", irq, IRQ_EN);
        applyStimulus(32'h40C, IRQ_EN ? 32'h6 : 32'h2);
        checkOutput("irq_after_clear_edge", irq, IRQ_EN);
        tick(1);
        checkOutput("irq_dropped", irq, 0);
        button = 0; tick(30);

        button = 1; tick(10);
        #2 reset = 1;
        readBus(32'h40C, rd); checkOutput("midreset_status", rd, 0);
        checkOutput("midreset_irq", irq, 0);
        checkOutput("midreset_leds", leds, 0);
        checkOutput("midreset_hex", hex, HEX_ZERO);
        @(posedge clk); #1; reset = 0;
        tick(17);
        readBus(32'h40C, rd); checkOutput("counter_cleared", rd, 0);
        tick(1);
        readBus(32'h40C, rd); checkOutput("press_after_reset", rd, 3);
        button = 0;

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
